// File: rtl/mem_sram_controller.sv
// MEM-stage sequencer: turns one 32-bit load/store into two timed half-word
// accesses on a 16-bit asynchronous SRAM, stalling the pipeline via ready.
module mem_sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES <= 4) ? 2 : $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_wr;
    logic [16:0]      r_word;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [17:0]      r_addr;
    logic [15:0]      r_dq_out;
    logic             r_oe;
    logic             r_we_n;

    logic             w_req;
    logic             w_wr_req;
    logic             w_last;
    logic [31:0]      w_offset;
    logic [16:0]      w_word;
    logic             w_unused_offset_bits;

    assign w_req    = rd_en | wr_en;
    // A simultaneous read and write is served as a read.
    assign w_wr_req = wr_en & ~rd_en;
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_offset = address - 32'(BASE_ADDR);
    assign w_word   = w_offset[18:2];
    assign w_unused_offset_bits = ^{w_offset[31:19], w_offset[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req)  w_next = S_LOW;
            S_LOW:   if (w_last) w_next = S_HIGH;
            S_HIGH:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign ready = (r_state == S_DONE) || ((r_state == S_IDLE) && !w_req);

    // SRAM pins are registered and set up one phase ahead, so address and data
    // are already stable on the first cycle of each write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_wr  <= 1'b0;
            r_word   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_addr   <= '0;
            r_dq_out <= '0;
            r_oe     <= 1'b0;
            r_we_n   <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_cnt    <= '0;
                        r_is_wr  <= w_wr_req;
                        r_word   <= w_word;
                        r_wdata  <= write_data;
                        r_addr   <= {w_word, 1'b0};
                        r_dq_out <= write_data[15:0];
                        r_oe     <= w_wr_req;
                        r_we_n   <= ~w_wr_req;
                    end
                end
                S_LOW: begin
                    if (!r_is_wr && w_last) begin
                        r_rdata[15:0] <= sram_dq_in;
                    end
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_addr   <= {r_word, 1'b1};
                        r_dq_out <= r_wdata[31:16];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!r_is_wr && w_last) begin
                        r_rdata[31:16] <= sram_dq_in;
                    end
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_oe   <= 1'b0;
                        r_we_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign read_data   = r_rdata;
    assign sram_addr   = r_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_oe;
    assign sram_we_n   = r_we_n;

endmodule

// File: doc/mem_sram_controller.md
# mem_sram_controller

Sequencer for the MEM stage's data-memory access. Converts a single-cycle 32-bit load/store request, as decoded by the control unit (`mem_read` / `mem_write`), into two timed half-word accesses on the board's 16-bit asynchronous SRAM. It holds `ready` low to freeze the pipeline until the access completes. It sits between the MEM-stage register and the SRAM pins.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, 3: cycles per half-word phase; must be at least 1.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset; one clock, synchronous and active-high.
- `rd_en` in 1: load request (MEM-stage `mem_read`).
- `wr_en` in 1: store request (MEM-stage `mem_write`).
- `address` in 32: byte address; word-aligned, bits [1:0] ignored.
- `write_data` in 32: store data.
- `read_data` out 32: load result.
- `ready` out 1: 0 means freeze the pipeline.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: data driven to SRAM.
- `sram_dq_oe` out 1: 1 means the top level drives `sram_dq_out` onto the DQ pins.
- `sram_dq_in` in 16: data read from the DQ pins.
- `sram_we_n` out 1: active-low SRAM write enable.

## Operation
- Address map:
  - `word = (address - BASE_ADDR) >> 2`, truncated to 17 bits.
  - Low half-word is at `sram_addr = {word, 1'b0}` and holds data [15:0].
  - High half-word is at `{word, 1'b1}` and holds data [31:16].
- States: IDLE, LOW, HIGH, DONE. A 2-bit-or-wider counter `cnt` counts the cycles within a phase.
- IDLE:
  - If `rd_en | wr_en`, latch the operation, `word` and `write_data`; clear `cnt`; go to LOW.
  - If both `rd_en` and `wr_en` are high, the request is treated as a read and the write is dropped.
- LOW:
  - `sram_addr = {word_l, 0}`.
  - Writes: `sram_dq_out = wdata_l[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0`.
  - Reads: `sram_dq_oe = 0`, `sram_we_n = 1`; `sram_dq_in` is captured into `read_data[15:0]` on the cycle where `cnt == WAIT_CYCLES-1`.
  - After `WAIT_CYCLES` cycles, clear `cnt` and go to HIGH.
- HIGH: same as LOW using `{word_l, 1}` and bits [31:16]. Go to DONE after `WAIT_CYCLES` cycles.
- DONE: one cycle. `sram_we_n = 1`, `sram_dq_oe = 0`, then unconditionally go to IDLE.
- `ready` (combinational):
  - 1 in DONE.
  - 1 in IDLE when `rd_en | wr_en` is low.
  - 0 otherwise, including in IDLE in the same cycle a request appears.
- `read_data` changes only on load captures. It holds its value through stores and idle periods.
- Latched operands are used for the whole transaction. Changes on `address`, `write_data`, `rd_en` or `wr_en` after acceptance are ignored.
- A request dropped mid-transaction is still completed; an SRAM write is never aborted.
- Outside LOW/HIGH of a write: `sram_we_n = 1`, `sram_dq_oe = 0`. `sram_addr` holds its last value.

## Timing
- Reset values: IDLE, `cnt = 0`, `read_data = 0`, `sram_addr = 0`, `sram_dq_out = 0`, `sram_dq_oe = 0`, `sram_we_n = 1`. `ready` is then 1 if no request is present.
- A request first seen in IDLE at cycle 0 runs:
  - LOW in cycles 1..W;
  - HIGH in cycles W+1..2W;
  - DONE in cycle 2W+1.
  - `ready` is low for 2W+1 cycles. With W=3, `ready` is low in cycles 0–6 and high in cycle 7.
- `read_data` is valid in DONE and remains stable until the next load capture. The MEM/WB register samples it at the end of DONE.
- Back-to-back requests: the pipeline advances at the end of DONE. The next request is seen in IDLE at 2W+2 and is accepted that cycle, giving 1 idle cycle between transactions.
- Write pulse: `sram_we_n` is low for W cycles per half. Address and data are stable for the whole pulse and change only at phase boundaries.
- Reset asserted in any state overrides everything: the next cycle shows reset values and the transaction is abandoned. The SRAM contents are then undefined for that word.

## Test plan
- Idle after reset, no request:
  - `ready = 1`, `sram_we_n = 1`, `sram_dq_oe = 0`, `read_data = 0`.
- Store 0xDEADBEEF to `address` 1024 with W=3:
  - `ready` low for 7 cycles.
  - SRAM model holds addr 0 = 0xBEEF and addr 1 = 0xDEAD.
  - `sram_we_n` low in cycles 1–6.
- Load from 1024 with the SRAM model preloaded as above:
  - `read_data = 0xDEADBEEF` in cycle 7, which is the DONE cycle with `ready = 1`.
- Store 0x12345678 to 1032, then load back-to-back with the request held across DONE:
  - The store hits `sram_addr` 4 (0x5678) and 5 (0x1234).
  - The load starts in cycle 8 and returns 0x12345678.
- `rd_en` and `wr_en` both high:
  - Treated as a read; `sram_we_n` never goes low; memory is unchanged.
- Reset in cycle 2 of a store:
  - The next cycle shows IDLE with `sram_we_n = 1`, `sram_dq_oe = 0`, `read_data = 0`.
  - A subsequent load completes normally in 2W+1 cycles.
